// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feed path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_pkg;

  // Feeder control states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } feeder_state_e;

  // Default element width; modules carry their own width_p and build
  // a local logic [width_p-1:0] element type from it.
  localparam int elem_width_lp = 8;
  typedef logic [elem_width_lp-1:0] elem_t;

  // Larger of two integers, usable in constant expressions
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Shift register of depth_p data+valid stages for one systolic edge lane.
// Latency: depth_p enabled shifts from data_i to data_o (last stage is the output).
// Backpressure: none; holds all stages while shift_i is low, clear_i empties it.
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int width_p = elem_width_lp,
  parameter int depth_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               shift_i,
  input  logic               clear_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               valid_o,
  output logic [width_p-1:0] data_o
);

  logic [depth_p-1:0][width_p-1:0] data_q;
  logic [depth_p-1:0]              valid_q;

  // Stage registers: clear on reset or abort, otherwise shift one stage per advance
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      data_q  <= '0;
      valid_q <= '0;
    end else if (clear_i) begin
      data_q  <= '0;
      valid_q <= '0;
    end else if (shift_i) begin
      for (int i = depth_p - 1; i > 0; i--) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
    end
  end

  assign data_o  = data_q[depth_p-1];
  assign valid_o = valid_q[depth_p-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Re-times accepted k-slices into a diagonal wavefront: A row r / B column c delayed r / c advances.
// Latency: lane 0 registered one edge after accept; lane n presents n advances later; done_o with the last lane.
// Backpressure: ready_o low while draining, while en_i is low, or during flush; no dependency on valid_i.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int width_p        = 8,
  parameter int array_height_p = 2,
  parameter int array_width_p  = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_ni,
  input  logic                              en_i,
  input  logic                              flush_i,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic                              last_i,
  input  logic [array_height_p*width_p-1:0] a_i,
  input  logic [array_width_p*width_p-1:0]  b_i,
  output logic [array_height_p*width_p-1:0] a_o,
  output logic [array_height_p-1:0]         a_valid_o,
  output logic [array_width_p*width_p-1:0]  b_o,
  output logic [array_width_p-1:0]          b_valid_o,
  output logic                              busy_o,
  output logic                              done_o
);

  typedef logic [width_p-1:0] lane_elem_t;

  // Extra advances needed after the last accept for the deepest lane to present it
  localparam int d_lp     = max_int(array_height_p, array_width_p) - 1;
  localparam int cnt_w_lp = (d_lp < 1) ? 1 : $clog2(d_lp + 1);
  localparam bit no_drain_lp = (d_lp == 0);

  feeder_state_e         state_q, state_d;
  logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  advance;
  logic                  accept;

  assign advance = en_i && !flush_i;
  assign ready_o = reset_ni && en_i && (state_q != ST_DRAIN) && !flush_i;
  assign accept  = valid_i && ready_o;
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;

  // Control registers: state, drain counter and the done pulse
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; done_d defaults low so done_o is a single-cycle pulse even across a stall
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (en_i) begin
      unique case (state_q)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            if (!last_i) begin
              state_d = ST_STREAM;
            end else if (no_drain_lp) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
              cnt_d   = cnt_w_lp'(d_lp);
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_q <= cnt_w_lp'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - cnt_w_lp'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A lanes: row r gets r+1 stages; bubbles carry zero data
  for (genvar r = 0; r < array_height_p; r++) begin : g_a_lane
    lane_elem_t lane_in;
    lane_elem_t lane_out;
    assign lane_in = accept ? a_i[r*width_p +: width_p] : '0;
    skew_delay_line #(.width_p(width_p), .depth_p(r + 1)) u_line (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .shift_i  (advance),
      .clear_i  (flush_i),
      .valid_i  (accept),
      .data_i   (lane_in),
      .valid_o  (a_valid_o[r]),
      .data_o   (lane_out)
    );
    assign a_o[r*width_p +: width_p] = lane_out;
  end

  // B lanes: column c gets c+1 stages
  for (genvar c = 0; c < array_width_p; c++) begin : g_b_lane
    lane_elem_t lane_in;
    lane_elem_t lane_out;
    assign lane_in = accept ? b_i[c*width_p +: width_p] : '0;
    skew_delay_line #(.width_p(width_p), .depth_p(c + 1)) u_line (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .shift_i  (advance),
      .clear_i  (flush_i),
      .valid_i  (accept),
      .data_i   (lane_in),
      .valid_o  (b_valid_o[c]),
      .data_o   (lane_out)
    );
    assign b_o[c*width_p +: width_p] = lane_out;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed table-driven bench for the skew feeder (2 A rows, 3 B columns, 8-bit elements).
// Latency: each table row is one clock; ready_o checked before the edge, outputs #1 after it.
// Backpressure: exercised through en_i stalls, drain, and flush rows.
module tb_systolic_skew_feeder;

  logic        clk_i;
  logic        reset_ni;
  logic        en_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic        last_i;
  logic [15:0] a_i;
  logic [23:0] b_i;
  logic [15:0] a_o;
  logic [1:0]  a_valid_o;
  logic [23:0] b_o;
  logic [2:0]  b_valid_o;
  logic        busy_o;
  logic        done_o;

  systolic_skew_feeder #(
    .width_p        (8),
    .array_height_p (2),
    .array_width_p  (3)
  ) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .en_i      (en_i),
    .flush_i   (flush_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .last_i    (last_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .a_o       (a_o),
    .a_valid_o (a_valid_o),
    .b_o       (b_o),
    .b_valid_o (b_valid_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en;
    logic        flush;
    logic        valid;
    logic        last;
    logic [15:0] a;
    logic [23:0] b;
    logic        exp_rdy;
    logic [15:0] exp_a;
    logic [1:0]  exp_av;
    logic [23:0] exp_b;
    logic [2:0]  exp_bv;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic add(input logic en, input logic flush, input logic valid, input logic last,
                     input logic [15:0] a, input logic [23:0] b, input logic rdy,
                     input logic [15:0] ea, input logic [1:0] eav,
                     input logic [23:0] eb, input logic [2:0] ebv,
                     input logic ebusy, input logic edone);
    vec_t v;
    v.en = en; v.flush = flush; v.valid = valid; v.last = last;
    v.a = a; v.b = b; v.exp_rdy = rdy;
    v.exp_a = ea; v.exp_av = eav; v.exp_b = eb; v.exp_bv = ebv;
    v.exp_busy = ebusy; v.exp_done = edone;
    vecs.push_back(v);
  endtask

  task automatic chk_outputs(input string tag, input logic [15:0] ea, input logic [1:0] eav,
                             input logic [23:0] eb, input logic [2:0] ebv,
                             input logic ebusy, input logic edone);
    chk({tag, " a_o"},       32'(a_o),       32'(ea));
    chk({tag, " a_valid_o"}, 32'(a_valid_o), 32'(eav));
    chk({tag, " b_o"},       32'(b_o),       32'(eb));
    chk({tag, " b_valid_o"}, 32'(b_valid_o), 32'(ebv));
    chk({tag, " busy_o"},    32'(busy_o),    32'(ebusy));
    chk({tag, " done_o"},    32'(done_o),    32'(edone));
  endtask

  initial begin
    // Single last beat: lane n presents n edges after accept, done with B lane 2
    //   en fl v  l  a         b            rdy exp_a     av     exp_b         bv      busy done
    add(1, 0, 1, 1, 16'h0201, 24'h302010, 1, 16'h0001, 2'b01, 24'h000010, 3'b001, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 0, 16'h0200, 2'b10, 24'h002000, 3'b010, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 0, 16'h0000, 2'b00, 24'h300000, 3'b100, 0, 1);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 1, 16'h0000, 2'b00, 24'h000000, 3'b000, 0, 0);
    // Bubble between two beats keeps relative skew
    add(1, 0, 1, 0, 16'hB0A0, 24'hE0D0C0, 1, 16'h00A0, 2'b01, 24'h0000C0, 3'b001, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 1, 16'hB000, 2'b10, 24'h00D000, 3'b010, 1, 0);
    add(1, 0, 1, 1, 16'hB1A1, 24'hE1D1C1, 1, 16'h00A1, 2'b01, 24'hE000C1, 3'b101, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 0, 16'hB100, 2'b10, 24'h00D100, 3'b010, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 0, 16'h0000, 2'b00, 24'hE10000, 3'b100, 0, 1);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 1, 16'h0000, 2'b00, 24'h000000, 3'b000, 0, 0);
    // Three beats with a 3-cycle en_i stall after the second accept
    add(1, 0, 1, 0, 16'h2010, 24'h504030, 1, 16'h0010, 2'b01, 24'h000030, 3'b001, 1, 0);
    add(1, 0, 1, 0, 16'h2111, 24'h514131, 1, 16'h2011, 2'b11, 24'h004031, 3'b011, 1, 0);
    add(0, 0, 1, 1, 16'h2212, 24'h524232, 0, 16'h2011, 2'b11, 24'h004031, 3'b011, 1, 0);
    add(0, 0, 1, 1, 16'h2212, 24'h524232, 0, 16'h2011, 2'b11, 24'h004031, 3'b011, 1, 0);
    add(0, 0, 1, 1, 16'h2212, 24'h524232, 0, 16'h2011, 2'b11, 24'h004031, 3'b011, 1, 0);
    add(1, 0, 1, 1, 16'h2212, 24'h524232, 1, 16'h2112, 2'b11, 24'h504132, 3'b111, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 0, 16'h2200, 2'b10, 24'h514200, 3'b110, 1, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 0, 16'h0000, 2'b00, 24'h520000, 3'b100, 0, 1);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 1, 16'h0000, 2'b00, 24'h000000, 3'b000, 0, 0);
    // Flush in drain, then a fresh beat, then flush racing a last beat
    add(1, 0, 1, 1, 16'h0706, 24'h0A0908, 1, 16'h0006, 2'b01, 24'h000008, 3'b001, 1, 0);
    add(1, 1, 0, 0, 16'h0000, 24'h000000, 0, 16'h0000, 2'b00, 24'h000000, 3'b000, 0, 0);
    add(1, 0, 1, 0, 16'h0C0B, 24'h0F0E0D, 1, 16'h000B, 2'b01, 24'h00000D, 3'b001, 1, 0);
    add(1, 1, 1, 1, 16'h1111, 24'h111111, 0, 16'h0000, 2'b00, 24'h000000, 3'b000, 0, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 1, 16'h0000, 2'b00, 24'h000000, 3'b000, 0, 0);
    add(1, 0, 0, 0, 16'h0000, 24'h000000, 1, 16'h0000, 2'b00, 24'h000000, 3'b000, 0, 0);

    // Reset held with valid_i high
    reset_ni = 1'b0;
    en_i     = 1'b1;
    flush_i  = 1'b0;
    valid_i  = 1'b1;
    last_i   = 1'b0;
    a_i      = 16'h5555;
    b_i      = 24'hAAAAAA;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset ready_o", 32'(ready_o), 32'd0);
    chk_outputs("reset", 16'h0, 2'b0, 24'h0, 3'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    valid_i  = 1'b0;
    reset_ni = 1'b1;
    #1;
    chk("post-reset ready_o", 32'(ready_o), 32'd1);
    chk("post-reset busy_o", 32'(busy_o), 32'd0);
    @(posedge clk_i);
    #1;

    foreach (vecs[i]) begin
      en_i    = vecs[i].en;
      flush_i = vecs[i].flush;
      valid_i = vecs[i].valid;
      last_i  = vecs[i].last;
      a_i     = vecs[i].a;
      b_i     = vecs[i].b;
      #1;
      chk($sformatf("row%0d ready_o", i), 32'(ready_o), 32'(vecs[i].exp_rdy));
      @(posedge clk_i);
      #1;
      chk_outputs($sformatf("row%0d", i), vecs[i].exp_a, vecs[i].exp_av,
                  vecs[i].exp_b, vecs[i].exp_bv, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Async reset between edges while streaming
    en_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1; last_i = 1'b0;
    a_i = 16'h3433; b_i = 24'h373635;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    chk("arst pre a_o", 32'(a_o), 32'h0033);
    chk("arst pre busy_o", 32'(busy_o), 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("arst ready_o", 32'(ready_o), 32'd0);
    chk_outputs("arst", 16'h0, 2'b0, 24'h0, 3'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    chk("arst release busy_o", 32'(busy_o), 32'd0);
    chk("arst release ready_o", 32'(ready_o), 32'd1);
    // A last beat from IDLE must enter drain, proving the state came back as IDLE
    valid_i = 1'b1; last_i = 1'b1; a_i = 16'h4241; b_i = 24'h454443;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0; last_i = 1'b0;
    chk("arst accept a_o", 32'(a_o), 32'h0041);
    chk("arst accept busy_o", 32'(busy_o), 32'd1);
    chk("arst accept ready_o", 32'(ready_o), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
